// File: rtl/spi_pkg.sv
// Shared types and sizing helpers for the framed SPI slave.
package spi_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, CHECK} state_e;

  localparam int ERR_W = 8;

  // bitcnt must reach BUFFER_SIZE+1 so over-length frames stay distinguishable
  function automatic int cnt_w(input int buffer_size);
    return $clog2(buffer_size + 2);
  endfunction
endpackage

// File: rtl/spi_slave_frame_if.sv
// SPI pins plus the tx/rx frame handshake between host logic and the slave.
interface spi_slave_frame_if #(parameter int BUFFER_SIZE = 64);
  logic                   SPI_SCK;
  logic                   SPI_SSEL;
  logic                   SPI_MOSI;
  logic                   SPI_MISO;
  logic [BUFFER_SIZE-1:0] tx_data;
  logic                   tx_ack;
  logic [BUFFER_SIZE-1:0] rx_data;
  logic                   rx_valid;

  modport slave  (input  SPI_SCK, SPI_SSEL, SPI_MOSI, tx_data,
                  output SPI_MISO, tx_ack, rx_data, rx_valid);
  modport master (output SPI_SCK, SPI_SSEL, SPI_MOSI, tx_data,
                  input  SPI_MISO, tx_ack, rx_data, rx_valid);
endinterface

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser with registered rise/fall pulses; presets to the line's idle level.
module spi_sync_edge #(
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [1:0] sync;
  logic       prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {2{IDLE_LEVEL}};
      prev <= IDLE_LEVEL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      prev <= sync[1];
      rise <= sync[1] & ~prev;
      fall <= ~sync[1] & prev;
    end
  end

  assign level = sync[1];
endmodule

// File: rtl/spi_slave_frame.sv
// Framed SPI slave, all four modes: one BUFFER_SIZE-bit exchange per SSEL assertion,
// length/MSGID checking, saturating error counters and a pkg_ok watchdog.
module spi_slave_frame
  import spi_pkg::*;
#(
  parameter int          BUFFER_SIZE    = 64,
  parameter logic [31:0] MSGID          = 32'h74697277,
  parameter bit          CPOL           = 1'b0,
  parameter bit          CPHA           = 1'b0,
  parameter int          TIMEOUT_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_slave_frame_if.slave bus,
  output logic             pkg_ok,
  output logic             busy,
  output logic [ERR_W-1:0] err_len_cnt,
  output logic [ERR_W-1:0] err_id_cnt
);
  localparam int CW   = cnt_w(BUFFER_SIZE);
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_e                 state, state_n;
  logic                   sck_lvl, sck_rise, sck_fall;
  logic                   ssel_lvl, ssel_rise, ssel_fall;
  logic [2:0]             mosi_sync;
  logic [1:0]             settle;
  logic                   armed, start;
  logic [BUFFER_SIZE-1:0] tx_shift, rx_shift, rx_data;
  logic [CW-1:0]          bitcnt;
  logic                   first_shift, rx_valid;
  logic                   sample_edge, shift_edge, len_ok, id_ok, good;
  logic [WD_W-1:0]        wd_cnt;

  spi_sync_edge #(.IDLE_LEVEL(CPOL)) u_sck (
    .clk(clk), .rst_n(rst_n), .din(bus.SPI_SCK),
    .level(sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.IDLE_LEVEL(1'b1)) u_ssel (
    .clk(clk), .rst_n(rst_n), .din(bus.SPI_SSEL),
    .level(ssel_lvl), .rise(ssel_rise), .fall(ssel_fall)
  );

  // third MOSI stage lines the data up with the registered SCK edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mosi_sync <= '0;
    else        mosi_sync <= {mosi_sync[1:0], bus.SPI_MOSI};
  end

  // Frames may start only after the bus has been seen idle on real (post-reset) samples,
  // so an SSEL held low through reset cannot masquerade as a fresh falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle <= '0;
      armed  <= 1'b0;
    end else begin
      settle <= {settle[0], 1'b1};
      armed  <= armed | (settle[1] & ssel_lvl & (sck_lvl == CPOL));
    end
  end

  assign sample_edge = (CPOL ^ CPHA) ? sck_fall : sck_rise;
  assign shift_edge  = (CPOL ^ CPHA) ? sck_rise : sck_fall;
  assign len_ok      = (bitcnt == CW'(BUFFER_SIZE));
  assign id_ok       = (rx_shift[BUFFER_SIZE-1 -: 32] == MSGID);
  assign good        = (state == CHECK) & len_ok & id_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      IDLE: if (ssel_fall && armed) begin
        state_n = ACTIVE;
        start   = 1'b1;
      end
      ACTIVE:  if (ssel_rise) state_n = CHECK;
      CHECK:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift    <= '0;
      rx_shift    <= '0;
      bitcnt      <= '0;
      first_shift <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      pkg_ok      <= 1'b0;
      wd_cnt      <= '0;
      err_len_cnt <= '0;
      err_id_cnt  <= '0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          tx_shift    <= bus.tx_data;
          bitcnt      <= '0;
          first_shift <= 1'b1;
        end
        ACTIVE: begin
          if (sample_edge) begin
            rx_shift <= {rx_shift[BUFFER_SIZE-2:0], mosi_sync[2]};
            if (bitcnt != CW'(BUFFER_SIZE + 1)) bitcnt <= bitcnt + 1'b1;
          end
          // CPHA=1: the leading edge of bit 0 must keep the MSB on the wire
          if (shift_edge) begin
            if (CPHA && first_shift) first_shift <= 1'b0;
            else                     tx_shift    <= {tx_shift[BUFFER_SIZE-2:0], 1'b0};
          end
        end
        CHECK: begin
          if (!len_ok) begin
            if (err_len_cnt != '1) err_len_cnt <= err_len_cnt + 1'b1;
          end else if (!id_ok) begin
            if (err_id_cnt != '1) err_id_cnt <= err_id_cnt + 1'b1;
          end
        end
        default: ;
      endcase

      if (good) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        pkg_ok   <= 1'b1;
        wd_cnt   <= '0;
      end else if (TIMEOUT_CYCLES != 0 && pkg_ok) begin
        wd_cnt <= wd_cnt + 1'b1;
        if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) pkg_ok <= 1'b0;
      end
    end
  end

  assign bus.SPI_MISO = (state == ACTIVE) & tx_shift[BUFFER_SIZE-1];
  assign bus.tx_ack   = start;
  assign bus.rx_data  = rx_data;
  assign bus.rx_valid = rx_valid;
  assign busy         = (state != IDLE);
endmodule
